// File: rtl/image_sensor_emulator_pkg.sv
// Shared image/sensor constants, pattern-select encoding and the test-pattern generator.
package image_sensor_emulator_pkg;

  localparam int unsigned SensorDoutWidth = 12;
  localparam int unsigned TriggerCycles   = 3840;
  localparam int unsigned ImageBitDepth   = 12;
  localparam int unsigned ImageMemSize    = 3072;

  typedef enum logic [1:0] {
    PatIndex   = 2'd0,  // running pixel index within the frame
    PatColumn  = 2'd1,  // column number
    PatConst   = 2'd2,  // fixed 12'hA5A
    PatChecker = 2'd3   // all-zero / all-one checkerboard
  } pattern_sel_e;

  typedef enum logic [2:0] {
    StIdle,
    StTrigger,
    StLead,
    StLine,
    StHblank,
    StTrail
  } sensor_state_e;

  // Pixel value for a given row/column; index pattern wraps modulo 2^SensorDoutWidth.
  function automatic logic [SensorDoutWidth-1:0] pattern_pixel(
    input pattern_sel_e sel,
    input logic [31:0]  row,
    input logic [31:0]  col,
    input logic [31:0]  width
  );
    logic [SensorDoutWidth-1:0] pix;
    pix = '0;
    unique case (sel)
      PatIndex:   pix = SensorDoutWidth'(row * width + col);
      PatColumn:  pix = SensorDoutWidth'(col);
      PatConst:   pix = 12'hA5A;
      PatChecker: pix = {SensorDoutWidth{row[0] ^ col[0]}};
      default:    pix = '0;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/sensor_pixclk_gen.sv
// Free-running divided pixel clock with a strobe marking the edge where it falls.
module sensor_pixclk_gen #(
  parameter int unsigned PIXCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pixclk_o,
  output logic fall_tick_o
);

  localparam int unsigned PhaseW = (PIXCLK_DIV > 2) ? $clog2(PIXCLK_DIV) : 1;
  localparam int unsigned Half   = PIXCLK_DIV / 2;

  logic [PhaseW-1:0] phase_q, phase_d;
  logic              pixclk_q, pixclk_d;

  // Next phase wraps at PIXCLK_DIV-1; pixclk is high for the first half of the period.
  always_comb begin
    phase_d  = (phase_q == PhaseW'(PIXCLK_DIV - 1)) ? '0 : phase_q + PhaseW'(1);
    pixclk_d = (phase_d < PhaseW'(Half));
  end

  // Phase and registered pixclk; reset parks at phase 0 with pixclk high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q  <= '0;
      pixclk_q <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      pixclk_q <= pixclk_d;
    end
  end

  assign pixclk_o    = pixclk_q;
  // The coming edge moves phase to Half, i.e. pixclk goes 1->0.
  assign fall_tick_o = (phase_q == PhaseW'(Half - 1));

endmodule

// File: rtl/image_sensor_emulator.sv
// Parallel image sensor model: trigger qualification, frame/line timing and test patterns.
module image_sensor_emulator
  import image_sensor_emulator_pkg::*;
#(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned HEIGHT      = 48,
  parameter int unsigned PIXCLK_DIV  = 4,
  parameter int unsigned HBLANK      = 8,
  parameter int unsigned VBLANK      = 4,
  parameter int unsigned TRIGGER_MIN = TriggerCycles
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sensorTrigger,
  input  logic [1:0]                 patternSel,
  output logic                       sensorPixclk,
  output logic                       sensorLineValid,
  output logic                       sensorFrameValid,
  output logic [SensorDoutWidth-1:0] sensorDout,
  output logic                       busy,
  output logic                       frameDone,
  output logic                       triggerShort
);

  localparam int unsigned ColW     = $clog2(WIDTH + 1);
  localparam int unsigned RowW     = $clog2(HEIGHT);
  localparam int unsigned MaxBlank = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int unsigned CntW     = $clog2(MaxBlank + 1);
  localparam int unsigned TrigW    = $clog2(TRIGGER_MIN + 1);

  logic fall_tick;

  sensor_pixclk_gen #(
    .PIXCLK_DIV (PIXCLK_DIV)
  ) u_pixclk (
    .clk_i       (clock),
    .rst_i       (reset),
    .pixclk_o    (sensorPixclk),
    .fall_tick_o (fall_tick)
  );

  sensor_state_e              state_q, state_d;
  logic [TrigW-1:0]           trig_cnt_q, trig_cnt_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [RowW-1:0]            row_q, row_d;
  logic [ColW-1:0]            col_q, col_d;
  pattern_sel_e               pat_q, pat_d;
  logic                       busy_q, busy_d;
  logic                       fv_q, fv_d;
  logic                       lv_q, lv_d;
  logic [SensorDoutWidth-1:0] dout_q, dout_d;
  logic                       done_q, done_d;
  logic                       short_q, short_d;
  logic                       emit;
  logic [ColW-1:0]            emit_col;

  // Next state: trigger qualification runs every cycle, frame timing advances on fall ticks.
  // col counts pixels already emitted, so col == WIDTH means the line is complete.
  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    pat_d      = pat_q;
    busy_d     = busy_q;
    fv_d       = fv_q;
    lv_d       = lv_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    short_d    = 1'b0;
    emit       = 1'b0;
    emit_col   = '0;

    unique case (state_q)
      StIdle: begin
        if (sensorTrigger) begin
          state_d    = StTrigger;
          trig_cnt_d = TrigW'(1);
        end
      end
      StTrigger: begin
        if (sensorTrigger) begin
          if (trig_cnt_q < TrigW'(TRIGGER_MIN)) trig_cnt_d = trig_cnt_q + TrigW'(1);
        end else if (trig_cnt_q >= TrigW'(TRIGGER_MIN)) begin
          pat_d      = pattern_sel_e'(patternSel);
          busy_d     = 1'b1;
          row_d      = '0;
          col_d      = '0;
          cnt_d      = '0;
          trig_cnt_d = '0;
          state_d    = StLead;
        end else begin
          short_d    = 1'b1;
          trig_cnt_d = '0;
          state_d    = StIdle;
        end
      end
      StLead: begin
        // First tick raises FrameValid; cnt tracks lead periods already shown.
        if (fall_tick) begin
          if (cnt_q == CntW'(VBLANK)) begin
            emit     = 1'b1;
            emit_col = '0;
            col_d    = ColW'(1);
            state_d  = StLine;
          end else begin
            fv_d  = 1'b1;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StLine: begin
        if (fall_tick) begin
          if (col_q == ColW'(WIDTH)) begin
            lv_d    = 1'b0;
            dout_d  = '0;
            cnt_d   = CntW'(1);
            col_d   = '0;
            state_d = (row_q == RowW'(HEIGHT - 1)) ? StTrail : StHblank;
          end else begin
            emit     = 1'b1;
            emit_col = col_q;
            col_d    = col_q + ColW'(1);
          end
        end
      end
      StHblank: begin
        if (fall_tick) begin
          if (cnt_q == CntW'(HBLANK)) begin
            row_d    = row_q + RowW'(1);
            emit     = 1'b1;
            emit_col = '0;
            col_d    = ColW'(1);
            state_d  = StLine;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StTrail: begin
        if (fall_tick) begin
          if (cnt_q == CntW'(VBLANK)) begin
            fv_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      lv_d   = 1'b1;
      dout_d = pattern_pixel(pat_q, 32'(row_d), 32'(emit_col), 32'(WIDTH));
    end
  end

  // State and output registers; reset abandons any frame without a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      trig_cnt_q <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pat_q      <= PatIndex;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      lv_q       <= 1'b0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pat_q      <= pat_d;
      busy_q     <= busy_d;
      fv_q       <= fv_d;
      lv_q       <= lv_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      short_q    <= short_d;
    end
  end

  assign sensorLineValid  = lv_q;
  assign sensorFrameValid = fv_q;
  assign sensorDout       = dout_q;
  assign busy             = busy_q;
  assign frameDone        = done_q;
  assign triggerShort     = short_q;

endmodule

// File: tb/tb_image_sensor_emulator.sv
// Self-checking bench: randomized frames compared against a frame-level timing/pattern model.
module tb_image_sensor_emulator;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned DIV  = 4;
  localparam int unsigned HB   = 2;
  localparam int unsigned VB   = 2;
  localparam int unsigned TMIN = 3840;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sensorTrigger = 1'b0;
  logic [1:0]  patternSel = 2'd0;
  logic        sensorPixclk;
  logic        sensorLineValid;
  logic        sensorFrameValid;
  logic [11:0] sensorDout;
  logic        busy;
  logic        frameDone;
  logic        triggerShort;

  int checks = 0;
  int failures = 0;

  // One entry {FrameValid, LineValid, Dout} per pixclk high phase with FrameValid set.
  logic [13:0] obs[$];
  int          done_cnt = 0;
  int          short_cnt = 0;
  bit          busy_seen = 1'b0;
  logic        pix_prev = 1'b1;

  image_sensor_emulator #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .PIXCLK_DIV  (DIV),
    .HBLANK      (HB),
    .VBLANK      (VB),
    .TRIGGER_MIN (TMIN)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .sensorTrigger    (sensorTrigger),
    .patternSel       (patternSel),
    .sensorPixclk     (sensorPixclk),
    .sensorLineValid  (sensorLineValid),
    .sensorFrameValid (sensorFrameValid),
    .sensorDout       (sensorDout),
    .busy             (busy),
    .frameDone        (frameDone),
    .triggerShort     (triggerShort)
  );

  always #5 clock = ~clock;

  // Passive monitor sampling between active edges.
  always @(negedge clock) begin
    if (reset) begin
      pix_prev = 1'b1;
    end else begin
      if (sensorPixclk && !pix_prev && sensorFrameValid)
        obs.push_back({sensorFrameValid, sensorLineValid, sensorDout});
      if (frameDone) done_cnt++;
      if (triggerShort) short_cnt++;
      if (busy) busy_seen = 1'b1;
      pix_prev = sensorPixclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_pix(input int sel, input int r, input int c);
    case (sel)
      0:       return 12'((r * W + c) % 4096);
      1:       return 12'(c % 4096);
      2:       return 12'hA5A;
      default: return ((r % 2) != (c % 2)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic compare_frame(input int sel, input string tag);
    logic [13:0] exp_q[$];
    for (int i = 0; i < VB; i++) exp_q.push_back(14'h2000);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) exp_q.push_back({2'b11, model_pix(sel, r, c)});
      if (r < H - 1) for (int i = 0; i < HB; i++) exp_q.push_back(14'h2000);
    end
    for (int i = 0; i < VB; i++) exp_q.push_back(14'h2000);
    check({tag, "_phases"}, 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("%s_ph%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_lv(input logic level, input string tag);
    int n = 0;
    while (sensorLineValid !== level && n < 500) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_lv_wait"}, 32'(sensorLineValid), 32'(level));
  endtask

  task automatic run_frame(input int sel, input int hold, input bit pulse_mid, input string tag);
    int d0;
    int s0;
    int n;
    obs.delete();
    d0 = done_cnt;
    s0 = short_cnt;
    @(negedge clock);
    patternSel    = 2'(sel);
    sensorTrigger = 1'b1;
    repeat (hold) @(negedge clock);
    sensorTrigger = 1'b0;
    repeat (2) @(negedge clock);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    // Latched selection must not follow later changes.
    patternSel = patternSel ^ 2'($urandom_range(1, 3));
    if (pulse_mid) begin
      wait_lv(1'b1, tag);
      sensorTrigger = 1'b1;
      repeat (5) @(negedge clock);
      sensorTrigger = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (4) @(negedge clock);
    compare_frame(sel, tag);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_no_short"}, 32'(short_cnt - s0), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_fv_off"}, 32'(sensorFrameValid), 32'd0);
  endtask

  task automatic run_short(input int hold, input string tag);
    int d0;
    int s0;
    obs.delete();
    d0 = done_cnt;
    s0 = short_cnt;
    @(negedge clock);
    busy_seen     = 1'b0;
    sensorTrigger = 1'b1;
    repeat (hold) @(negedge clock);
    sensorTrigger = 1'b0;
    repeat (30) @(negedge clock);
    check({tag, "_short_once"}, 32'(short_cnt - s0), 32'd1);
    check({tag, "_no_fv"}, 32'(obs.size()), 32'd0);
    check({tag, "_no_busy"}, 32'(busy_seen), 32'd0);
    check({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixclk"}, 32'(sensorPixclk), 32'd1);
    check({tag, "_lv"}, 32'(sensorLineValid), 32'd0);
    check({tag, "_fv"}, 32'(sensorFrameValid), 32'd0);
    check({tag, "_dout"}, 32'(sensorDout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frameDone), 32'd0);
    check({tag, "_short"}, 32'(triggerShort), 32'd0);
  endtask

  initial begin
    int hi;
    int tot;
    int n;
    int d0;

    // Reset values.
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Pixclk period and duty.
    n = 0;
    while (sensorPixclk !== 1'b0 && n < 20) begin @(negedge clock); n++; end
    while (sensorPixclk !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    hi = 0;
    tot = 0;
    while (sensorPixclk === 1'b1 && tot < 20) begin @(negedge clock); hi++; tot++; end
    while (sensorPixclk === 1'b0 && tot < 20) begin @(negedge clock); tot++; end
    check("pixclk_high", 32'(hi), 32'(DIV / 2));
    check("pixclk_period", 32'(tot), 32'(DIV));

    run_frame(0, TMIN + 1, 1'b0, "f_pat0");
    run_short(100, "short100");
    run_short(TMIN - 1, "short_edge");
    run_frame(3, TMIN, 1'b0, "f_pat3_minhold");
    run_frame(int'($urandom_range(0, 3)), TMIN + int'($urandom_range(0, 30)), 1'b1, "f_midpulse");
    for (int f = 0; f < 2; f++)
      run_frame(int'($urandom_range(0, 3)), TMIN + int'($urandom_range(0, 30)), 1'b0,
                $sformatf("f_rand%0d", f));

    // Reset during the second line.
    obs.delete();
    d0 = done_cnt;
    @(negedge clock);
    patternSel    = 2'd1;
    sensorTrigger = 1'b1;
    repeat (TMIN + 1) @(negedge clock);
    sensorTrigger = 1'b0;
    wait_lv(1'b1, "mid_l0");
    wait_lv(1'b0, "mid_hb");
    wait_lv(1'b1, "mid_l1");
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_fv_idle", 32'(sensorFrameValid), 32'd0);
    run_frame(int'($urandom_range(0, 3)), TMIN + 1, 1'b0, "f_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
